mux4_key_bank: RTL and testbench
================================

# mux4_key_bank

Parametrised bank of NUM_MUX 4-input key-gates for logic-locked ISCAS netlists. Each gate selects one of four stored key bits from two circuit nets. It generalises the fixed p1..p8 primary-input key scheme to a serially loaded, parity-checked key held in a shadow/active register pair. The bank sits between the key-programming interface and the locked combinational core; its mux outputs replace the locked internal nets (e.g. N185, N254 equivalents).

## Interface
- NUM_MUX, default 2: number of mux4 key-gates.
- KEY_W, default 4*NUM_MUX: key length in bits. Derived; never overridden.
- CNT_W, default $clog2(KEY_W+1): bit-counter width. Derived.

Ports:
- CK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- key_start  input  1  begin (or restart) a key load.
- key_din  input  1  serial key/parity bit, LSB first.
- key_valid  input  1  key_din valid; a bit transfers when key_valid & key_ready.
- key_ready  output  1  high only in SHIFT.
- sel_a  input  NUM_MUX  low select bit per gate.
- sel_b  input  NUM_MUX  high select bit per gate.
- mux_out  output  NUM_MUX  registered gate outputs.
- armed  output  1  active key valid.
- key_err  output  1  last load failed parity; sticky until next good load or RST.
- busy  output  1  state != IDLE.

## Operation
- Registers:
  - shadow[KEY_W-1:0] shift register.
  - active[KEY_W-1:0].
  - par_bit.
  - cnt[CNT_W-1:0].
  - state: IDLE, SHIFT, CHECK.
- Gate function: for gate i, with {sel_b[i],sel_a[i]} = 00/01/10/11, the output selects active[4i+0]/[4i+1]/[4i+2]/[4i+3] respectively.
- If armed=0, every mux_out bit is 0 regardless of selects. This is the fail-safe value.
- IDLE:
  - On key_start: clear shadow, set cnt=0, go to SHIFT.
  - key_valid is ignored.
- SHIFT:
  - Each transfer with cnt<KEY_W writes shadow[cnt]=key_din and increments cnt.
  - The transfer with cnt==KEY_W captures par_bit and goes to CHECK.
  - key_start in SHIFT restarts the load: shadow cleared, cnt=0, stay in SHIFT. Any key_valid bit in that same cycle is discarded.
- CHECK (exactly one cycle; key_start ignored):
  - Parity is even over the key plus its parity bit.
  - Pass (^shadow ^ par_bit == 0): active<=shadow, armed<=1, key_err<=0.
  - Fail: active<=0, armed<=0, key_err<=1.
  - Either way, go to IDLE.
- active and armed change only in CHECK or on RST. While a reload is in progress, the old key keeps driving mux_out.
- RST at any time, including mid-load: state=IDLE, cnt=0, shadow=0, active=0, par_bit=0.

## Timing
- Reset values: mux_out=0, armed=0, key_err=0, key_ready=0, busy=0.
- key_start sampled in cycle t moves to SHIFT; key_ready=1 from cycle t+1.
- A load takes KEY_W+1 accepted transfers. Gaps in key_valid stall the load without bound; there is no timeout.
- The last transfer happens in cycle u. CHECK runs in u+1. armed, key_err and active are updated at the end of u+1, visible in u+2. busy=0 from u+2.
- mux_out latency is 1 cycle: selects sampled at edge k appear on mux_out after edge k, using the active/armed values from before edge k. After a commit at the end of u+1, mux_out first reflects the new key after edge u+2.
- key_start simultaneous with the parity transfer in SHIFT: restart wins and the parity bit is discarded.
- RST has priority over every other input.

## Test plan
1. Reset. Assert RST for 2 cycles with random inputs.
   - mux_out=00, armed=0, key_err=0, key_ready=0, busy=0.
2. Good load, NUM_MUX=2. Pulse key_start, then send 8'hA5 LSB first, then parity 0.
   - armed=1 two cycles after the last bit.
   - Gate 0 (active[3:0]=4'b0101), selects 00/01/10/11 give 1/0/1/0.
   - Gate 1 (active[7:4]=4'b1010), selects 00/01/10/11 give 0/1/0/1.
   - Each result appears one cycle after the select is applied.
3. Bad parity. Send 8'h3C with parity 1.
   - key_err=1, armed=0, mux_out=00 for every select combination.
4. Reload while armed. With 8'hA5 armed, load 8'hFF with parity 0 and random key_valid gaps.
   - mux_out follows A5 throughout the shift.
   - After commit, mux_out=11 for every select.
5. Restart. Pulse key_start after 5 bits, then send a full 8'h0F with parity 0.
   - Only 8'h0F is committed: gate 0 gives all-1, gate 1 gives all-0.
6. Reset mid-load. Assert RST after 3 bits of a reload over an armed key.
   - armed=0 and mux_out=00 on the next cycle; state IDLE.
   - A subsequent full load of 8'hA5 behaves as in scenario 2.

Source files
------------

// File: rtl/mux4_key_bank.sv
// mux4_key_bank: bank of NUM_MUX 4-input key-gates driven by a serially loaded, parity-checked key
//   CK, RST               clock, synchronous active-high reset
//   key_start             begin or restart a key load
//   key_din, key_valid    serial key then parity bit, LSB first
//   key_ready             high while accepting serial bits
//   sel_a, sel_b          per-gate selects {sel_b,sel_a} picking active[4i+sel]
//   mux_out               registered gate outputs, forced to 0 while not armed
//   armed, key_err, busy  key valid, sticky parity failure, load in progress
module mux4_key_bank #(
    parameter int NUM_MUX = 2,
    parameter int KEY_W   = 4 * NUM_MUX,
    parameter int CNT_W   = $clog2(KEY_W + 1)
) (
    input  logic               CK,
    input  logic               RST,
    input  logic               key_start,
    input  logic               key_din,
    input  logic               key_valid,
    output logic               key_ready,
    input  logic [NUM_MUX-1:0] sel_a,
    input  logic [NUM_MUX-1:0] sel_b,
    output logic [NUM_MUX-1:0] mux_out,
    output logic               armed,
    output logic               key_err,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;
    state_t             state_q;
    logic [KEY_W-1:0]   shadow_q, active_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               par_q, armed_q, err_q;
    logic [NUM_MUX-1:0] mux_q, mux_d;
    for (genvar g = 0; g < NUM_MUX; g++) begin : g_mux
        logic [3:0] quad;
        assign quad     = active_q[4*g +: 4];
        assign mux_d[g] = armed_q & quad[{sel_b[g], sel_a[g]}];
    end
    always_ff @(posedge CK) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
            par_q    <= 1'b0;
            armed_q  <= 1'b0;
            err_q    <= 1'b0;
            mux_q    <= '0;
        end else begin
            mux_q <= mux_d;
            case (state_q)
                IDLE: if (key_start) begin
                    shadow_q <= '0;
                    cnt_q    <= '0;
                    state_q  <= SHIFT;
                end
                SHIFT: if (key_start) begin
                    shadow_q <= '0;
                    cnt_q    <= '0;
                end else if (key_valid) begin
                    if (cnt_q == CNT_W'(KEY_W)) begin
                        par_q   <= key_din;
                        state_q <= CHECK;
                    end else begin
                        // LSB-first shift: after KEY_W bits the first bit sits at shadow[0]
                        shadow_q <= {key_din, shadow_q[KEY_W-1:1]};
                        cnt_q    <= cnt_q + 1'b1;
                    end
                end
                CHECK: begin
                    active_q <= (^shadow_q ^ par_q) ? '0 : shadow_q;
                    armed_q  <= ~(^shadow_q ^ par_q);
                    err_q    <= ^shadow_q ^ par_q;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign mux_out   = mux_q;
    assign armed     = armed_q;
    assign key_err   = err_q;
    assign key_ready = state_q == SHIFT;
    assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_mux4_key_bank.sv
// tb_mux4_key_bank: scoreboard bench with randomized stimulus against a queue-based reference model
module tb_mux4_key_bank;
    localparam int NUM_MUX = 2;
    localparam int KEY_W   = 4 * NUM_MUX;
    logic CK = 1'b1, RST = 1'b0, key_start = 1'b0, key_din = 1'b0, key_valid = 1'b0;
    logic key_ready, armed, key_err, busy;
    logic [NUM_MUX-1:0] sel_a = '0, sel_b = '0, mux_out;
    typedef struct packed {
        logic [NUM_MUX-1:0] mux;
        logic armed, err, busy, ready;
    } exp_t;
    exp_t sb_q[$];
    int n_checks = 0, n_fail = 0;
    bit m_loading = 0, m_check = 0, m_armed = 0, m_err = 0;
    logic [KEY_W-1:0] m_key = '0;
    bit m_bits[$];
    mux4_key_bank #(.NUM_MUX(NUM_MUX)) dut (
        .CK(CK), .RST(RST), .key_start(key_start), .key_din(key_din),
        .key_valid(key_valid), .key_ready(key_ready), .sel_a(sel_a), .sel_b(sel_b),
        .mux_out(mux_out), .armed(armed), .key_err(key_err), .busy(busy)
    );
    always #5 CK = ~CK;
    function automatic logic [NUM_MUX-1:0] gates(input logic [KEY_W-1:0] k,
                                                 input logic [NUM_MUX-1:0] a, input logic [NUM_MUX-1:0] b);
        logic [NUM_MUX-1:0] r;
        for (int i = 0; i < NUM_MUX; i++) r[i] = k[4*i + 2*int'(b[i]) + int'(a[i])];
        return r;
    endfunction
    task automatic chk(input string name, input logic [NUM_MUX-1:0] act, input logic [NUM_MUX-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask
    always @(posedge CK) begin
        exp_t e;
        #1;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_empty at %0t: got no expectation expected one", $time);
        end else begin
            e = sb_q.pop_front();
            chk("mux_out", mux_out, e.mux);
            chk("armed", NUM_MUX'(armed), NUM_MUX'(e.armed));
            chk("key_err", NUM_MUX'(key_err), NUM_MUX'(e.err));
            chk("busy", NUM_MUX'(busy), NUM_MUX'(e.busy));
            chk("key_ready", NUM_MUX'(key_ready), NUM_MUX'(e.ready));
        end
    end
    task automatic cyc(input bit rst, input bit start, input bit valid, input bit din);
        exp_t e;
        int ones;
        logic [KEY_W-1:0] k;
        @(negedge CK);
        RST = rst; key_start = start; key_valid = valid; key_din = din;
        sel_a = NUM_MUX'($urandom); sel_b = NUM_MUX'($urandom);
        e.mux = (m_armed && !rst) ? gates(m_key, sel_a, sel_b) : '0;
        if (rst) begin
            m_loading = 0; m_check = 0; m_armed = 0; m_err = 0; m_key = '0;
            m_bits.delete();
        end else if (m_check) begin
            ones = 0;
            k = '0;
            for (int i = 0; i < KEY_W; i++) k[i] = m_bits[i];
            foreach (m_bits[i]) ones += int'(m_bits[i]);
            m_armed = (ones % 2) == 0;
            m_err   = !m_armed;
            m_key   = m_armed ? k : '0;
            m_check = 0;
        end else if (m_loading) begin
            if (start) m_bits.delete();
            else if (valid) begin
                m_bits.push_back(din);
                if (m_bits.size() == KEY_W + 1) begin
                    m_loading = 0;
                    m_check = 1;
                end
            end
        end else if (start) begin
            m_loading = 1;
            m_bits.delete();
        end
        e.armed = m_armed; e.err = m_err; e.busy = m_loading | m_check; e.ready = m_loading;
        sb_q.push_back(e);
    endtask
    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 1'($urandom), 1'($urandom));
    endtask
    task automatic send_bits(input logic [KEY_W-1:0] k, input int n, input int gap_pct);
        for (int i = 0; i < n; i++) begin
            while (int'($urandom_range(99)) < gap_pct) cyc(0, 0, 0, 1'($urandom));
            cyc(0, 0, 1, k[i]);
        end
    endtask
    task automatic load(input logic [KEY_W-1:0] k, input bit par, input int gap_pct);
        cyc(0, 1, 1'($urandom), 1'($urandom));
        send_bits(k, KEY_W, gap_pct);
        while (int'($urandom_range(99)) < gap_pct) cyc(0, 0, 0, 1'($urandom));
        cyc(0, 0, 1, par);
        cyc(0, 1'($urandom), 1'($urandom), 1'($urandom));
    endtask
    initial begin
        repeat (2) cyc(1, 1'($urandom), 1'($urandom), 1'($urandom));
        idle(3);
        load(8'hA5, 0, 0);
        idle(12);
        load(8'h3C, 1, 0);
        idle(8);
        load(8'hA5, 0, 0);
        idle(2);
        load(8'hFF, 0, 40);
        idle(10);
        cyc(0, 1, 0, 0);
        send_bits(8'h5A, 5, 0);
        cyc(0, 1, 1, 1);
        send_bits(8'h0F, KEY_W, 20);
        cyc(0, 0, 1, 0);
        idle(10);
        load(8'hA5, 0, 0);
        idle(2);
        cyc(0, 1, 0, 0);
        send_bits(8'h33, 3, 0);
        cyc(1, 1'($urandom), 1'($urandom), 1'($urandom));
        idle(3);
        load(8'hA5, 0, 0);
        idle(10);
        cyc(0, 1, 0, 0);
        send_bits(8'h81, KEY_W, 0);
        cyc(0, 1, 1, 0);
        send_bits(8'hC3, KEY_W, 0);
        cyc(0, 0, 1, 0);
        idle(8);
        repeat (8) begin
            load(KEY_W'($urandom), 1'($urandom), 30);
            idle(6);
        end
        @(posedge CK);
        #2;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
